// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbiter sharing one memory port between instruction fetch and load/store
//
// Purpose:
//   Grants the single byte-addressable memory to either the instruction-fetch
//   port or the data port. The arbiter then runs the access through the memory's
//   fixed read latency, or through its write-complete handshake with a timeout.
//   It returns data and the error flag to the granted port with a one-cycle ack.
//   When both ports are waiting in IDLE, the grant alternates between them.
//   Every output is registered.
//
// Ports:
//   clk        in   1   clock, posedge
//   rst        in   1   asynchronous active-low reset
//   i_req      in   1   fetch request, held until i_ack
//   i_addr     in   32  fetch address
//   i_ack      out  1   one-cycle fetch completion pulse
//   i_rdata    out  32  fetch data, holds its last value between acks
//   i_err      out  1   fetch error, qualified by i_ack
//   d_req      in   1   data request, held until d_ack
//   d_addr     in   32  data address
//   d_wsize    in   2   0 read, 1 byte, 2 half-word, 3 word write
//   d_wdata    in   32  data write data
//   d_ack      out  1   one-cycle data completion pulse
//   d_rdata    out  32  data read data, holds its last value between acks
//   d_err      out  1   data error, qualified by d_ack
//   mem_addr   out  32  memory address, holds its value in IDLE
//   mem_write  out  2   memory write size, nonzero only in WRITE
//   mem_wdata  out  32  memory write data
//   mem_rdata  in   32  memory read data
//   mem_done   in   1   memory write complete
//   mem_error  in   1   memory alignment error
//   busy       out  1   high whenever the arbiter is not in IDLE
//   grant      out  1   owner of current/last access: 0 fetch, 1 data

module mem_arbiter #(
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_wsize,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_error,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // The counter reaches 0 in the last cycle of the wait. Loading N-1 therefore
    // gives exactly N cycles in READ, or at most N cycles in WRITE.
    localparam logic [7:0] READ_LOAD  = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WRITE_LOAD = 8'(WRITE_TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;

    logic        i_ack_next, d_ack_next;
    logic [31:0] i_rdata_next, d_rdata_next;
    logic        i_err_next, d_err_next;
    logic [31:0] mem_addr_next, mem_wdata_next;
    logic [1:0]  mem_write_next;
    logic        busy_next, grant_next;

    // The data port wins when it is the only requester. It also wins a
    // contested cycle when the fetch port owned the previous access.
    logic        pick_d;
    assign pick_d = d_req & (~i_req | ~grant);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_write <= 2'd0;
            busy      <= 1'b0;
            grant     <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            i_ack     <= i_ack_next;
            d_ack     <= d_ack_next;
            i_rdata   <= i_rdata_next;
            d_rdata   <= d_rdata_next;
            i_err     <= i_err_next;
            d_err     <= d_err_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            mem_write <= mem_write_next;
            busy      <= busy_next;
            grant     <= grant_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        i_ack_next     = 1'b0;
        d_ack_next     = 1'b0;
        i_rdata_next   = i_rdata;
        d_rdata_next   = d_rdata;
        i_err_next     = i_err;
        d_err_next     = d_err;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        mem_write_next = 2'd0;
        grant_next     = grant;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_next    = pick_d;
                    mem_addr_next = pick_d ? d_addr : i_addr;
                    if (pick_d && (d_wsize != 2'd0)) begin
                        mem_wdata_next = d_wdata;
                        mem_write_next = d_wsize;
                        cnt_next       = WRITE_LOAD;
                        state_next     = WRITE;
                    end else begin
                        cnt_next   = READ_LOAD;
                        state_next = READ;
                    end
                end
            end

            READ: begin
                if (cnt == 8'd0) begin
                    // Only the granted port's results are touched. The other
                    // port keeps whatever it last returned.
                    if (grant) begin
                        d_rdata_next = mem_rdata;
                        d_err_next   = mem_error;
                        d_ack_next   = 1'b1;
                    end else begin
                        i_rdata_next = mem_rdata;
                        i_err_next   = mem_error;
                        i_ack_next   = 1'b1;
                    end
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end

            WRITE: begin
                if (mem_done) begin
                    d_err_next = mem_error;
                    d_ack_next = 1'b1;
                    state_next = RESP;
                end else if (cnt == 8'd0) begin
                    d_err_next = 1'b1;
                    d_ack_next = 1'b1;
                    state_next = RESP;
                end else begin
                    mem_write_next = mem_write;
                    cnt_next       = cnt - 8'd1;
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule
